// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one request at a time on a
// registered req/ack instruction-memory port and buffers returned words in a
// small prefetch FIFO that feeds the datapath over valid/ready.
// A redirect restarts fetch at the branch target and flushes wrong-path words.
// Optional build macro IFU_PERF_EN adds discard and full-stall counters.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
`ifdef IFU_PERF_EN
   output logic [31:0] perf_discard_cnt,
   output logic [31:0] perf_full_cnt,
`endif
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle = 2'd0, StReq = 2'd1, StDiscard = 2'd2} state_e;

   state_e        r_state, w_state_nxt;
   logic          r_req, w_req_nxt;
   logic [31:0]   r_addr, w_addr_nxt;
   logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
   logic [CW-1:0] r_count, w_count_nxt, w_count_after_pop;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_pop;
   logic [31:0]   r_mem_instr [DEPTH];
   logic [31:0]   r_mem_pc    [DEPTH];
   logic [31:0]   r_instr, r_instr_pc, w_head_instr, w_head_pc;
   logic          w_ack, w_pop, w_push, w_flush, w_drop, w_valid;
   logic [31:0]   w_redirect_pc;

   assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
   // An ack with no request outstanding (e.g. after a reset) is ignored.
   assign w_ack   = imem_ack & r_req;
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & instr_ready;

   // Fetch FSM next-state, request control and FIFO push/flush decisions.
   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_addr_nxt     = r_addr;
      w_fetch_pc_nxt = r_fetch_pc;
      w_push         = 1'b0;
      w_flush        = 1'b0;
      w_drop         = 1'b0;
      case (r_state)
         StIdle: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
               w_flush        = 1'b1;
            end else if (r_count < FULL_CNT) begin
               // A free slot now guarantees room when the ack arrives.
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_fetch_pc;
               w_state_nxt = StReq;
            end
         end
         StReq: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
               w_flush        = 1'b1;
               if (w_ack) begin
                  w_drop      = 1'b1;
                  w_req_nxt   = 1'b0;
                  w_state_nxt = StIdle;
               end else begin
                  // Request must stay up until acked; its data is wrong-path.
                  w_state_nxt = StDiscard;
               end
            end else if (w_ack) begin
               w_push         = 1'b1;
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               w_req_nxt      = 1'b0;
               w_state_nxt    = StIdle;
            end
         end
         StDiscard: begin
            if (redirect) begin
               w_fetch_pc_nxt = w_redirect_pc;
               w_flush        = 1'b1;
            end
            if (w_ack) begin
               w_drop      = 1'b1;
               w_req_nxt   = 1'b0;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // FIFO occupancy and the registered head word presented to the datapath.
   always_comb begin
      w_count_after_pop = r_count - CW'(w_pop);
      w_rd_ptr_pop      = r_rd_ptr + PW'(w_pop);
      w_count_nxt       = w_flush ? '0 : (w_count_after_pop + CW'(w_push));
      w_head_instr      = r_instr;
      w_head_pc         = r_instr_pc;
      // Head holds its last value when the FIFO goes empty.
      if (!w_flush && (w_count_nxt != '0)) begin
         if (w_count_after_pop == '0) begin
            w_head_instr = imem_rdata;
            w_head_pc    = r_addr;
         end else begin
            w_head_instr = r_mem_instr[w_rd_ptr_pop];
            w_head_pc    = r_mem_pc[w_rd_ptr_pop];
         end
      end
   end

   // Control state, request port, fetch PC, count and head registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_addr     <= w_addr_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_count    <= w_count_nxt;
         r_instr    <= w_head_instr;
         r_instr_pc <= w_head_pc;
      end
   end

   // FIFO read/write pointers; a flush realigns both to slot 0.
   always_ff @(posedge clk) begin
      if (!rst || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_push);
         r_rd_ptr <= w_rd_ptr_pop;
      end
   end

   // FIFO storage write; contents are only meaningful below the count.
   always_ff @(posedge clk) begin
      if (rst && w_push) begin
         r_mem_instr[r_wr_ptr] <= imem_rdata;
         r_mem_pc[r_wr_ptr]    <= r_addr;
      end
   end

`ifdef IFU_PERF_EN
   logic [31:0] r_perf_discard, r_perf_full;

   // Saturating counters for dropped responses and full-FIFO idle cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf_discard <= '0;
         r_perf_full    <= '0;
      end else begin
         if (w_drop && (r_perf_discard != 32'hFFFF_FFFF)) begin
            r_perf_discard <= r_perf_discard + 32'd1;
         end
         if ((r_state == StIdle) && (r_count == FULL_CNT) &&
             (r_perf_full != 32'hFFFF_FFFF)) begin
            r_perf_full <= r_perf_full + 32'd1;
         end
      end
   end

   assign perf_discard_cnt = r_perf_discard;
   assign perf_full_cnt    = r_perf_full;
`endif

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = w_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural memory model, a
// scoreboard queue of expected {pc, word} entries, a redirect vector table and
// hand-written sequences for stall, discard, wrap and mid-request reset.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk, rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
   logic [31:0] perf_discard_cnt, perf_full_cnt;
`endif

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef IFU_PERF_EN
      .perf_discard_cnt(perf_discard_cnt),
      .perf_full_cnt   (perf_full_cnt),
`endif
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   typedef struct {
      logic [31:0] rpc;
      int unsigned delay;
      logic [31:0] exp_first;
      logic [31:0] exp_second;
   } redir_vec_t;

   exp_t        sb_q[$];
   logic [31:0] req_log[$];
   logic [31:0] consumed[$];
   int          n_chk, n_fail;
   int          mem_lat, mem_wait;
   bit          mem_en;
   bit          rst_was, exp_hold, exp_disc;
   logic [31:0] hold_addr;
   int          size_before;
   int unsigned exp_drops, exp_full;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model step using the inputs about to be sampled at the next edge.
   task automatic model_update();
      bit ack_eff;
      size_before = sb_q.size();
      rst_was     = rst;
      if (!rst) begin
         sb_q.delete();
         exp_hold  = 0;
         exp_disc  = 0;
         exp_drops = 0;
         exp_full  = 0;
      end else begin
         ack_eff = imem_req && imem_ack;
         if (!imem_req && size_before == DEPTH) exp_full++;
         if (instr_valid && instr_ready && sb_q.size() != 0 && !redirect) begin
            consumed.push_back(sb_q[0].pc);
            void'(sb_q.pop_front());
         end
         if (redirect) sb_q.delete();
         if (ack_eff && !redirect && !exp_disc)
            sb_q.push_back('{pc: imem_addr, word: mem_word(imem_addr)});
         if (ack_eff && (redirect || exp_disc)) exp_drops++;
         if (ack_eff) exp_disc = 0;
         else if (redirect && imem_req) exp_disc = 1;
         exp_hold  = imem_req && !imem_ack;
         hold_addr = imem_addr;
      end
   endtask

   task automatic check_outputs();
      if (!rst_was) begin
         chk("rst_req", {31'd0, imem_req}, 32'd0);
         chk("rst_addr", imem_addr, RESET_PC);
         chk("rst_valid", {31'd0, instr_valid}, 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_pc", instr_pc, 32'd0);
      end else begin
         chk("valid", {31'd0, instr_valid}, {31'd0, sb_q.size() != 0});
         if (sb_q.size() != 0) begin
            chk("head_pc", instr_pc, sb_q[0].pc);
            chk("head_instr", instr, sb_q[0].word);
         end
         if (exp_hold) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, hold_addr);
         end else if (imem_req === 1'b1) begin
            req_log.push_back(imem_addr);
            chk("req_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (size_before == DEPTH) chk("req_when_full", {31'd0, imem_req}, 32'd0);
         end
      end
`ifdef IFU_PERF_EN
      chk("perf_discard", perf_discard_cnt, exp_drops);
      chk("perf_full", perf_full_cnt, exp_full);
`endif
   endtask

   task automatic mem_drive();
      if (imem_req !== 1'b1 || !mem_en) begin
         imem_ack = 1'b0;
         if (imem_req !== 1'b1) mem_wait = 0;
      end else if (mem_wait >= mem_lat) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
         mem_wait   = 0;
      end else begin
         imem_ack = 1'b0;
         mem_wait++;
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      mem_drive();
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      redirect = 1'b0;
      mem_en   = 1;
      tick();
      tick();
      req_log.delete();
      consumed.delete();
      rst = 1'b1;
   endtask

   task automatic wait_req();
      for (int n = 0; n < 30 && imem_req !== 1'b1; n++) tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic wait_log(input int cnt);
      for (int n = 0; n < 60 && req_log.size() < cnt; n++) tick();
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
   endfunction

   redir_vec_t tbl[5];

   initial begin
      tbl[0] = '{rpc: 32'h0000_0103, delay: 0, exp_first: 32'h0000_0100, exp_second: 32'h0000_0104};
      tbl[1] = '{rpc: 32'h0000_0040, delay: 1, exp_first: 32'h0000_0040, exp_second: 32'h0000_0044};
      tbl[2] = '{rpc: 32'hFFFF_FFFE, delay: 0, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000};
      tbl[3] = '{rpc: 32'h0000_2007, delay: 1, exp_first: 32'h0000_2004, exp_second: 32'h0000_2008};
      tbl[4] = '{rpc: 32'h8000_0000, delay: 0, exp_first: 32'h8000_0000, exp_second: 32'h8000_0004};

      n_chk = 0; n_fail = 0;
      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0; mem_lat = 1; mem_wait = 0; mem_en = 1;
      exp_hold = 0; exp_disc = 0; exp_drops = 0; exp_full = 0;

      // 1: in-order fetch with a one-cycle memory.
      do_reset();
      instr_ready = 1'b1;
      tick();
      chk("t1_first_req", {31'd0, imem_req}, 32'd1);
      chk("t1_first_addr", imem_addr, RESET_PC);
      for (int n = 0; n < 20; n++) tick();
      for (int i = 0; i < 4; i++) begin
         chk("t1_req_addr", log_at(i), 32'(i * 4));
         chk("t1_consumed", (i < consumed.size()) ? consumed[i] : 32'hxxxx_xxxx, 32'(i * 4));
      end

      // 2: stalled consumer fills the FIFO, then fetch resumes.
      instr_ready = 1'b0;
      mem_lat = 0;
      do_reset();
      for (int n = 0; n < 30; n++) tick();
      chk("t2_req_count", req_log.size(), 32'(DEPTH));
      chk("t2_req_idle", {31'd0, imem_req}, 32'd0);
      chk("t2_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      req_log.delete();
      wait_log(1);
      chk("t2_resume_addr", log_at(0), 32'h10);

      // 3: redirect while a request is outstanding; late ack is dropped.
      mem_lat = 1;
      do_reset();
      for (int n = 0; n < 30 && !(imem_req === 1'b1 && imem_addr == 32'h8); n++) tick();
      chk("t3_req8", imem_addr, 32'h8);
      mem_en = 0;
      imem_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      chk("t3_addr_hold", imem_addr, 32'h8);
      chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
      tick();
      tick();
      imem_ack = 1'b1; imem_rdata = mem_word(32'h8);
      tick();
      chk("t3_req_drop", {31'd0, imem_req}, 32'd0);
      mem_en = 1;
      req_log.delete();
      wait_log(1);
      chk("t3_next_addr", log_at(0), 32'h100);

      // 4: redirect coincides with an ack and a pop.
      instr_ready = 1'b0;
      do_reset();
      for (int n = 0; n < 30 && !(imem_ack === 1'b1 && instr_valid === 1'b1); n++) tick();
      chk("t4_setup", {31'd0, imem_ack & instr_valid}, 32'd1);
      instr_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      chk("t4_valid", {31'd0, instr_valid}, 32'd0);
`ifdef IFU_PERF_EN
      chk("t4_perf_discard", perf_discard_cnt, 32'd1);
`endif
      req_log.delete();
      wait_log(1);
      chk("t4_next_addr", log_at(0), 32'h40);

      // Redirect table, including target alignment and address wrap.
      for (int i = 0; i < 5; i++) begin
         wait_req();
         for (int d = 0; d < int'(tbl[i].delay); d++) tick();
         redirect = 1'b1; redirect_pc = tbl[i].rpc;
         tick();
         redirect = 1'b0;
         req_log.delete();
         wait_log(2);
         chk("tbl_first", log_at(0), tbl[i].exp_first);
         chk("tbl_second", log_at(1), tbl[i].exp_second);
      end

      // 5: reset mid-request, then a stray ack while idle.
      mem_en = 0;
      wait_req();
      rst = 1'b0;
      tick();
      chk("t5_rst_req", {31'd0, imem_req}, 32'd0);
      chk("t5_rst_addr", imem_addr, RESET_PC);
      rst = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      chk("t5_stray_valid", {31'd0, instr_valid}, 32'd0);
      chk("t5_new_req", {31'd0, imem_req}, 32'd1);
      chk("t5_new_addr", imem_addr, RESET_PC);
      mem_en = 1;
      for (int n = 0; n < 10; n++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
